// File: rtl/sha256_pkg.sv
// Shared definitions for the sha256 message front end.
//   BLK_W      : width of one padded message block in bits
//   BLK_BYTES  : bytes per block
//   LEN_BYTE   : first byte slot of the 64-bit big-endian length field
//   PAD_BYTE   : marker byte written right after the last message byte
//   pad_state_t: padder FSM states
package sha256_pkg;

    localparam int          BLK_W     = 512;
    localparam int          BLK_BYTES = 64;
    localparam int          LEN_BYTE  = 56;
    localparam logic [7:0]  PAD_BYTE  = 8'h80;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        EMIT_FULL  = 2'd1,
        EMIT_TAIL  = 2'd2,
        EMIT_EXTRA = 2'd3
    } pad_state_t;

endpackage

// File: rtl/sha256_pad_mask.sv
// Combinational padding mask for a partially filled block.
// Byte slot i lives at bits [511-8*i -: 8].
//   n      in  7    number of message bytes in the block (0..64)
//   keep   out 64   keep[i]=1 for byte slots holding message data (i < n)
//   marker out 512  0x80 in byte slot n, zeros elsewhere (all zero when n=64)
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  logic [6:0]           n,
    output logic [BLK_BYTES-1:0] keep,
    output logic [BLK_W-1:0]     marker
);

    always_comb begin
        keep   = '0;
        marker = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            keep[i] = (7'(i) < n);
            if (7'(i) == n) begin
                marker[BLK_W-1-8*i -: 8] = PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a last-flagged byte stream into padded
// 512-bit blocks (0x80 marker, zero fill, 64-bit big-endian bit length),
// adding an extra block when the tail leaves no room for the length.
//   clk        in  1    clock
//   rst        in  1    synchronous active-high reset
//   in_data    in  8    message byte
//   in_valid   in  1    in_data valid
//   in_last    in  1    final byte of message
//   in_nodata  in  1    with in_valid&in_last: message ends, no byte carried
//   in_ready   out 1    byte accepted when in_valid&in_ready
//   blk_data   out 512  padded block, byte 0 at [511:504]
//   blk_valid  out 1    block available
//   blk_ready  in  1    block taken when blk_valid&blk_ready
//   blk_first  out 1    first block of a message
//   blk_last   out 1    final block of a message
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_nodata,
    output logic             in_ready,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_first,
    output logic             blk_last
);

    pad_state_t           state, state_nxt;
    logic [5:0]           cnt;
    logic [LEN_W-1:0]     bitlen;
    logic [BLK_W-1:0]     buffer;
    logic                 first_pend;
    logic                 tail_last;   // tail block already carries the length
    logic                 extra_80;    // extra block must start with the marker

    logic                 accept;
    logic                 nodata;
    logic                 msg_done;
    logic [6:0]           n;
    logic [LEN_W-1:0]     bitlen_nxt;
    logic [63:0]          len_field;
    logic [BLK_W-1:0]     wr_buf;
    logic [BLK_W-1:0]     pad_buf;
    logic [BLK_W-1:0]     extra_blk;
    logic [BLK_BYTES-1:0] keep;
    logic [BLK_W-1:0]     marker;

    assign accept     = in_valid & in_ready;
    // nodata only has meaning on the closing transfer
    assign nodata     = in_last & in_nodata;
    assign n          = {1'b0, cnt} + (nodata ? 7'd0 : 7'd1);
    assign bitlen_nxt = bitlen + (nodata ? '0 : LEN_W'(8));
    assign len_field  = 64'(bitlen_nxt);
    assign extra_blk  = {(extra_80 ? PAD_BYTE : 8'h00), {(BLK_W-72){1'b0}}, 64'(bitlen)};
    assign msg_done   = blk_ready & ((state == EMIT_EXTRA) | ((state == EMIT_TAIL) & tail_last));

    sha256_pad_mask u_mask (
        .n      (n),
        .keep   (keep),
        .marker (marker)
    );

    // Current block with the incoming byte dropped into slot cnt.
    always_comb begin
        wr_buf = buffer;
        if (!nodata) begin
            wr_buf[BLK_W-1-8*int'(cnt) -: 8] = in_data;
        end
    end

    // Closing block: data bytes, marker, zero fill, and the length when it fits.
    always_comb begin
        pad_buf = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            pad_buf[BLK_W-1-8*i -: 8] = keep[i] ? wr_buf[BLK_W-1-8*i -: 8] : 8'h00;
        end
        pad_buf = pad_buf | marker;
        if (n < 7'(LEN_BYTE)) begin
            pad_buf[63:0] = len_field;
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (in_last)                         state_nxt = EMIT_TAIL;
                    else if (cnt == 6'(BLK_BYTES - 1))   state_nxt = EMIT_FULL;
                end
            end
            EMIT_FULL:  if (blk_ready) state_nxt = FILL;
            EMIT_TAIL:  if (blk_ready) state_nxt = tail_last ? FILL : EMIT_EXTRA;
            EMIT_EXTRA: if (blk_ready) state_nxt = FILL;
            default:    state_nxt = FILL;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        in_ready  = (state == FILL);
        blk_valid = (state != FILL);
        blk_first = first_pend & (state != EMIT_EXTRA);
        blk_last  = (state == EMIT_EXTRA) | ((state == EMIT_TAIL) & tail_last);
    end

    assign blk_data = buffer;

    // ---- Block buffer, counters and message flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer     <= '0;
            cnt        <= '0;
            bitlen     <= '0;
            first_pend <= 1'b1;
            tail_last  <= 1'b0;
            extra_80   <= 1'b0;
        end else if (msg_done) begin
            buffer     <= '0;
            cnt        <= '0;
            bitlen     <= '0;
            first_pend <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        bitlen <= bitlen_nxt;
                        if (in_last) begin
                            buffer    <= pad_buf;
                            cnt       <= '0;
                            tail_last <= (n < 7'(LEN_BYTE));
                            extra_80  <= (n == 7'(BLK_BYTES));
                        end else begin
                            buffer <= wr_buf;
                            cnt    <= cnt + 6'd1;
                        end
                    end
                end
                EMIT_FULL: begin
                    if (blk_ready) begin
                        buffer     <= '0;
                        cnt        <= '0;
                        first_pend <= 1'b0;
                    end
                end
                EMIT_TAIL: begin
                    // tail_last case is handled by msg_done above
                    if (blk_ready) buffer <= extra_blk;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed vectors plus randomized messages,
// checked against a byte-queue padding model and a block scoreboard.
module tb_sha256_padder;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 416'h0, 64'h0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_nodata = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    logic         man_rdy = 1'b1;
    logic         rnd_rdy = 1'b1;
    logic         rand_rdy = 1'b0;
    logic         gaps = 1'b0;

    int           n_checks = 0;
    int           n_fail = 0;
    blk_t         exp_q[$];

    assign blk_ready = rand_rdy ? rnd_rdy : man_rdy;

    always #5 clk = ~clk;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_nodata (in_nodata),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Padding model: message bytes, 0x80, zeros to 56 mod 64, 64-bit length.
    task automatic model_push(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] len;
        blk_t        b;
        int          nb;
        p   = msg;
        len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
        nb = p.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            b.d = '0;
            for (int i = 0; i < 64; i++) b.d[511-8*i -: 8] = p[64*bi+i];
            b.f = (bi == 0);
            b.l = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic push_lit(input logic [511:0] d);
        blk_t b;
        b.d = d; b.f = 1'b1; b.l = 1'b1;
        exp_q.push_back(b);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_xfer(input logic [7:0] d, input logic l, input logic nd);
        bit acc = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = d; in_last = l; in_nodata = nd;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; in_nodata = 1'b0;
        if (!acc) check("in_timeout", 512'd0, 512'd1);
    endtask

    // mode 0: last on final byte, 1: nodata-last after bytes, 2: no end
    task automatic send_msg(input logic [7:0] msg[$], input int mode);
        int m = (msg.size() == 0) ? 1 : mode;
        for (int i = 0; i < msg.size(); i++)
            drive_xfer(msg[i], (m == 0) && (i == msg.size() - 1), 1'b0);
        if (m == 1) drive_xfer(8'($urandom), 1'b1, 1'b1);
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain", 512'(exp_q.size()), 512'd0);
    endtask

    task automatic monitor();
        blk_t e;
        forever begin
            @(negedge clk);
            if (!rst && blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_blk", 512'd1, 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_data", blk_data, e.d);
                    check("blk_first", 512'(blk_first), 512'(e.f));
                    check("blk_last", 512'(blk_last), 512'(e.l));
                end
            end
        end
    endtask

    task automatic rdy_gen();
        forever begin
            @(posedge clk); #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [7:0] msg[$];
        string      s;
        int         bl[12] = '{0, 1, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

        fork
            monitor();
            rdy_gen();
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_blk_valid", 512'(blk_valid), 512'd0);
        check("rst_in_ready",  512'(in_ready),  512'd1);
        check("rst_blk_first", 512'(blk_first), 512'd1);
        check("rst_blk_last",  512'(blk_last),  512'd0);
        check("rst_blk_data",  blk_data,        512'd0);
        @(posedge clk); #1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        push_lit(ABC_BLK);
        send_msg(msg, 0);
        check("abc_latency", 512'(blk_valid), 512'd1);
        drain();

        // empty message
        msg.delete();
        push_lit(EMPTY_BLK);
        send_msg(msg, 1);
        drain();

        // 56-byte message: length spills into an extra block
        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        model_push(msg);
        send_msg(msg, 0);
        drain();

        // 64 bytes 0x00..0x3f: full block then marker+length block
        msg.delete();
        for (int i = 0; i < 64; i++) msg.push_back(8'(i));
        model_push(msg);
        send_msg(msg, 0);
        drain();

        // backpressure on "abc"
        man_rdy = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        push_lit(ABC_BLK);
        send_msg(msg, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid",    512'(blk_valid), 512'd1);
            check("bp_data",     blk_data,        ABC_BLK);
            check("bp_in_ready", 512'(in_ready),  512'd0);
        end
        @(posedge clk); #1;
        man_rdy = 1'b1;
        drain();
        check("bp_released", 512'(blk_valid), 512'd0);

        // next message is again a first block
        push_lit(ABC_BLK);
        send_msg(msg, 0);
        drain();

        // reset in the middle of a message
        msg.delete();
        for (int i = 0; i < 30; i++) msg.push_back(8'($urandom));
        send_msg(msg, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_blk_valid", 512'(blk_valid), 512'd0);
        check("midrst_in_ready",  512'(in_ready),  512'd1);
        msg = '{8'h61, 8'h62, 8'h63};
        push_lit(ABC_BLK);
        send_msg(msg, 0);
        drain();

        // boundary lengths then random lengths, random gaps and backpressure
        rand_rdy = 1'b1;
        gaps     = 1'b1;
        for (int k = 0; k < 32; k++) begin
            int len = (k < 12) ? bl[k] : int'($urandom_range(0, 140));
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            model_push(msg);
            send_msg(msg, int'($urandom_range(0, 1)));
            drain();
        end

        check("queue_empty", 512'(exp_q.size()), 512'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
